brc_resolve: RTL

- Branch-resolution stage that sits directly downstream of the branch comparator. It consumes the comparator's taken decision together with the branch operands, predicted direction and predicted target.
- Computes the real next PC and link value, and detects mispredicts and misaligned targets.
- Broadcasts a resolve result to the ROB/writeback and drives a held redirect request to fetch through a valid/ready handshake.

---
 rtl/brc_resolve_if.sv | 45 ++++
 rtl/brc_resolve.sv | 124 ++++++++++++
 2 files changed

// File: rtl/brc_resolve_if.sv
// Branch-resolve port bundle: op input handshake, resolve broadcast, redirect handshake
// and the mispredict counter.
interface brc_resolve_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_imm;
  logic             in_jump;
  logic             in_jalr;
  logic             in_taken;
  logic             in_pred_taken;
  logic [XLEN-1:0]  in_pred_target;

  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_mispredict;
  logic             res_exc;
  logic [XLEN-1:0]  res_link;

  logic             redir_valid;
  logic             redir_ready;
  logic [XLEN-1:0]  redir_pc;

  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output in_valid, in_tag, in_pc, in_rs1, in_imm, in_jump, in_jalr, in_taken,
           in_pred_taken, in_pred_target, redir_ready,
    input  in_ready, res_valid, res_tag, res_mispredict, res_exc, res_link,
           redir_valid, redir_pc, mispred_cnt
  );

  modport slave (
    input  in_valid, in_tag, in_pc, in_rs1, in_imm, in_jump, in_jalr, in_taken,
           in_pred_taken, in_pred_target, redir_ready,
    output in_ready, res_valid, res_tag, res_mispredict, res_exc, res_link,
           redir_valid, redir_pc, mispred_cnt
  );
endinterface

// File: rtl/brc_resolve.sv
// Branch resolution: computes next PC / link, flags mispredicts and misaligned targets,
// broadcasts a one-cycle result and holds a redirect request until fetch accepts it.
module brc_resolve #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  brc_resolve_if.slave bus
);

  typedef enum logic {StIdle, StPend} redir_state_e;

  redir_state_e state_q, state_d;

  logic             s1_valid_q;
  logic [TAG_W-1:0] tag_q;
  logic             mispred_q;
  logic             exc_q;
  logic [XLEN-1:0]  link_q;
  logic [XLEN-1:0]  next_q;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             capture;
  logic [XLEN-1:0]  link;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  next_pc;
  logic             taken_eff;
  logic             exc;
  logic             mispred;

  assign capture = bus.in_valid && bus.in_ready;

  // Resolve on the input side so s1 holds only finished results.
  always_comb begin
    link = bus.in_pc + XLEN'(4);
    if (bus.in_jalr) begin
      target = (bus.in_rs1 + bus.in_imm) & ~XLEN'(1);
    end else begin
      target = bus.in_pc + bus.in_imm;
    end
    taken_eff = bus.in_jump || bus.in_taken;
    next_pc   = taken_eff ? target : link;
    exc       = taken_eff && target[1];
    // A not-taken op never compares targets: a stale predicted target is harmless.
    mispred   = !exc && ((taken_eff != bus.in_pred_taken) ||
                         (taken_eff && (target != bus.in_pred_target)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      tag_q      <= '0;
      mispred_q  <= 1'b0;
      exc_q      <= 1'b0;
      link_q     <= '0;
      next_q     <= '0;
    end else begin
      s1_valid_q <= capture && !flush;
      if (capture) begin
        tag_q     <= bus.in_tag;
        mispred_q <= mispred;
        exc_q     <= exc;
        link_q    <= link;
        next_q    <= next_pc;
      end
    end
  end

  // Redirect is only raised from idle; younger results arriving while one is pending
  // are on the wrong path and must not disturb the held request.
  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    cnt_d      = cnt_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s1_valid_q && mispred_q) begin
            state_d    = StPend;
            redir_pc_d = next_q;
          end
        end
        StPend: begin
          if (bus.redir_ready) begin
            state_d = StIdle;
            if (!(&cnt_q)) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      redir_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready       = rst_n && (state_q == StIdle);
  assign bus.res_valid      = s1_valid_q && !flush;
  assign bus.res_tag        = tag_q;
  assign bus.res_mispredict = bus.res_valid && mispred_q;
  assign bus.res_exc        = bus.res_valid && exc_q;
  assign bus.res_link       = link_q;
  assign bus.redir_valid    = (state_q == StPend);
  assign bus.redir_pc       = redir_pc_q;
  assign bus.mispred_cnt    = cnt_q;

endmodule
